// File: rtl/m_uart_receiver.sv
// m_uart_receiver
//   UART receive end for 8N1-style framing (start 0, WORD data bits LSB
//   first, stop 1). RXD is sampled on a OVERSAMPLE-per-bit tick. The
//   recovered word is offered on a valid/ready handshake.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   RXD        serial line (idles high, asynchronous to clk)
//   data_o     last received word, stable while valid=1
//   valid      data_o holds an unread word
//   ready      consumer accepts the word on a clk edge with valid & ready
//   busy       a frame is in progress (state != IDLE)
//   frame_err  sticky: a stop bit was sampled low
//   overrun    sticky: a frame completed while the previous word was unread
//   err_clr    clears frame_err/overrun on the next edge (a same-edge set wins)
//   state      IDLE=00 START=01 DATA=10 STOP=11
module m_uart_receiver #(
  parameter int WORD       = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 16_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RXD,
  output logic [WORD-1:0] data_o,
  output logic            valid,
  input  logic            ready,
  output logic            busy,
  output logic            frame_err,
  output logic            overrun,
  input  logic            err_clr,
  output logic [1:0]      state
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = $clog2(OVERSAMPLE);
  localparam int BW      = (WORD > 1) ? $clog2(WORD) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_DATA  = 2'b10,
    S_STOP  = 2'b11
  } st_t;

  // Synchronizer: sync1 -> rx_s (used by all logic) -> rx_d (edge detect only)
  logic sync1_q, rx_s_q, rx_d_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      sync1_q <= RXD;
      rx_s_q  <= sync1_q;
      rx_d_q  <= rx_s_q;
    end
  end

  // Free-running oversample tick divider
  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + 1'b1;
  end

  // Receive FSM and datapath
  st_t             st_q, st_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [BW-1:0]   bidx_q, bidx_d;
  logic [WORD-1:0] sh_q, sh_d;
  logic [WORD-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q    <= S_IDLE;
      tcnt_q  <= '0;
      bidx_q  <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      tcnt_q  <= tcnt_d;
      bidx_q  <= bidx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    tcnt_d  = tcnt_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q;
    // Clear first so that an error detected on the same edge overrides it
    ferr_d  = err_clr ? 1'b0 : ferr_q;
    ovr_d   = err_clr ? 1'b0 : ovr_q;

    if (valid_q && ready) valid_d = 1'b0;

    case (st_q)
      S_IDLE: begin
        // Needs a high-to-low transition; a line stuck low never re-arms
        if (rx_d_q && !rx_s_q) begin
          tcnt_d = '0;
          st_d   = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (tcnt_q == TW'(OVERSAMPLE/2 - 1)) begin
            if (!rx_s_q) begin
              tcnt_d = '0;
              bidx_d = '0;
              st_d   = S_DATA;
            end else begin
              st_d   = S_IDLE;   // false start: glitch, no flags
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tcnt_q == TW'(OVERSAMPLE - 1)) begin
            sh_d[bidx_q] = rx_s_q;
            tcnt_d       = '0;
            if (bidx_q == BW'(WORD - 1)) st_d = S_STOP;
            else                         bidx_d = bidx_q + 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (tcnt_q == TW'(OVERSAMPLE - 1)) begin
            st_d = S_IDLE;
            if (rx_s_q) begin
              // An accept on this same edge frees the slot for the new word
              if (!valid_q || ready) begin
                data_d  = sh_q;
                valid_d = 1'b1;
              end else begin
                ovr_d   = 1'b1;
              end
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  assign data_o    = data_q;
  assign valid     = valid_q;
  assign busy      = (st_q != S_IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign state     = st_q;

endmodule

// File: tb/tb_m_uart_receiver.sv
module tb_m_uart_receiver;

  logic       clk = 1'b0;
  logic       reset, RXD, ready, err_clr;
  logic [7:0] data_o;
  logic       valid, busy, frame_err, overrun;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  m_uart_receiver #(
    .WORD(8), .BAUD_RATE(1_000_000), .CLK_FREQ(16_000_000),
    .OVERSAMPLE(16), .DIV_W(12)
  ) dut (
    .clk(clk), .reset(reset), .RXD(RXD), .data_o(data_o), .valid(valid),
    .ready(ready), .busy(busy), .frame_err(frame_err), .overrun(overrun),
    .err_clr(err_clr), .state(state)
  );

  // Capture every handshake that the next rising edge will complete
  always @(negedge clk)
    if (reset && valid && ready) got_q.push_back(data_o);

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    RXD = 1'b0; step(16);
    for (int i = 0; i < 8; i++) begin RXD = d[i]; step(16); end
    RXD = stop_b; step(16);
    RXD = 1'b1;
  endtask

  task automatic test_reset;
    tests++;
    if ({data_o, valid, busy, frame_err, overrun, state} !== 14'h0) begin
      fails++;
      $display("FAIL reset_state: got data=%h v=%b b=%b fe=%b ov=%b st=%b, want all 0",
               data_o, valid, busy, frame_err, overrun, state);
    end
  endtask

  task automatic test_single;
    logic [7:0] e, g;
    ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    step(2);
    tests++;
    if (valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", valid); end
    tests++;
    if (data_o !== 8'hA5) begin fails++; $display("FAIL single_data: got %h want a5", data_o); end
    tests++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL single_ferr: got %b want 0", frame_err); end
    ready = 1'b1; step(1); ready = 1'b0;
    tests++;
    if (valid !== 1'b0) begin fails++; $display("FAIL single_accept: valid got %b want 0", valid); end
    e = exp_q.pop_front();
    tests++;
    if (got_q.size() == 0) begin fails++; $display("FAIL single_sb: got no word want %h", e); end
    else begin
      g = got_q.pop_front();
      if (g !== e) begin fails++; $display("FAIL single_sb: got %h want %h", g, e); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] vals [3] = '{8'h00, 8'hFF, 8'h55};
    logic [7:0] e, g;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(vals[i]);
      send_frame(vals[i], 1'b1);
    end
    step(20);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      tests++;
      if (got_q.size() == 0) begin fails++; $display("FAIL b2b_sb%0d: got no word want %h", i, e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin fails++; $display("FAIL b2b_sb%0d: got %h want %h", i, g, e); end
      end
    end
    tests++;
    if ({frame_err, overrun, valid} !== 3'b000) begin
      fails++; $display("FAIL b2b_flags: got fe/ov/v=%b want 000", {frame_err, overrun, valid});
    end
  endtask

  task automatic test_frame_err;
    logic [7:0] e, g;
    ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    step(16);
    tests++;
    if (frame_err !== 1'b1) begin fails++; $display("FAIL ferr_set: got %b want 1", frame_err); end
    tests++;
    if (valid !== 1'b0) begin fails++; $display("FAIL ferr_valid: got %b want 0", valid); end
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    tests++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL ferr_clr: got %b want 0", frame_err); end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    step(4);
    tests++;
    if ({valid, data_o} !== {1'b1, 8'h3C}) begin
      fails++; $display("FAIL ferr_resend: got v=%b data=%h want v=1 data=3c", valid, data_o);
    end
    ready = 1'b1; step(1); ready = 1'b0;
    e = exp_q.pop_front();
    tests++;
    if (got_q.size() == 0) begin fails++; $display("FAIL ferr_sb: got no word want %h", e); end
    else begin
      g = got_q.pop_front();
      if (g !== e) begin fails++; $display("FAIL ferr_sb: got %h want %h", g, e); end
    end
  endtask

  task automatic test_glitch_overrun;
    logic [7:0] e, g;
    ready = 1'b0;
    RXD = 1'b0; step(4); RXD = 1'b1;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy: got %b want 1", busy); end
    step(24);
    tests++;
    if ({state, valid, frame_err} !== 4'b0000) begin
      fails++; $display("FAIL glitch_idle: got st=%b v=%b fe=%b want 00 0 0", state, valid, frame_err);
    end
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1); step(16);
    send_frame(8'h22, 1'b1); step(16);
    tests++;
    if (data_o !== 8'h11) begin fails++; $display("FAIL ovr_data: got %h want 11", data_o); end
    tests++;
    if ({valid, overrun} !== 2'b11) begin
      fails++; $display("FAIL ovr_flag: got v/ov=%b want 11", {valid, overrun});
    end
    ready = 1'b1; step(1); ready = 1'b0;
    e = exp_q.pop_front();
    tests++;
    if (got_q.size() == 0) begin fails++; $display("FAIL ovr_sb: got no word want %h", e); end
    else begin
      g = got_q.pop_front();
      if (g !== e) begin fails++; $display("FAIL ovr_sb: got %h want %h", g, e); end
    end
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clr: got %b want 0", overrun); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d = 8'h96;
    logic [7:0] e, g;
    ready = 1'b0;
    RXD = 1'b0; step(16);
    for (int i = 0; i < 4; i++) begin RXD = d[i]; step(16); end
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b want 1", busy); end
    reset = 1'b0; RXD = 1'b1; #1;
    tests++;
    if ({data_o, valid, busy, frame_err, overrun, state} !== 14'h0) begin
      fails++; $display("FAIL mid_reset: got data=%h v=%b b=%b st=%b want all 0",
                        data_o, valid, busy, state);
    end
    step(3);
    reset = 1'b1;
    step(20);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    step(4);
    tests++;
    if ({valid, data_o, frame_err, overrun} !== {1'b1, 8'h5A, 2'b00}) begin
      fails++; $display("FAIL mid_after: got v=%b data=%h fe=%b ov=%b want 1 5a 0 0",
                        valid, data_o, frame_err, overrun);
    end
    ready = 1'b1; step(1); ready = 1'b0;
    e = exp_q.pop_front();
    tests++;
    if (got_q.size() == 0) begin fails++; $display("FAIL mid_sb: got no word want %h", e); end
    else begin
      g = got_q.pop_front();
      if (g !== e) begin fails++; $display("FAIL mid_sb: got %h want %h", g, e); end
    end
    tests++;
    if (got_q.size() != 0) begin
      fails++; $display("FAIL sb_extra: got %0d extra words want 0", got_q.size());
    end
  endtask

  initial begin
    reset = 1'b0; RXD = 1'b1; ready = 1'b0; err_clr = 1'b0;
    step(3);
    test_reset;
    reset = 1'b1;
    step(20);
    test_single;
    step(10);
    test_back_to_back;
    step(10);
    test_frame_err;
    step(10);
    test_glitch_overrun;
    step(10);
    test_reset_midframe;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/m_uart_receiver.md
Name: m_uart_receiver

Overview:
- UART receive end, pairing with the team's UART transmitter on the same serial link.
- Frame format: 8N1, i.e. one start bit (0), WORD data bits LSB first, one stop bit (1).
- Samples RXD with a 16x oversample tick, recovers the data word, and presents it on a valid/ready handshake to the MPU-side consumer.
- Flags framing errors and overruns.

Parameters:
- WORD, 8: data bits per frame.
- BAUD_RATE, 115200: line bit rate.
- CLK_FREQ, 16_000_000: clk frequency in Hz.
- OVERSAMPLE, 16: ticks per bit. Must be an even number ≥ 4.
- DIV_W, 12: width of the tick divider counter.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- RXD, input, 1: serial line. Idles high. Asynchronous to clk.
- data_o, output, WORD: last received word.
- valid, output, 1: data_o holds an unread word.
- ready, input, 1: consumer accepts the word when valid & ready.
- busy, output, 1: a frame is in progress (state != IDLE).
- frame_err, output, 1: sticky. Stop bit was sampled 0.
- overrun, output, 1: sticky. A frame completed while valid was still high.
- err_clr, input, 1: clears frame_err and overrun on the next edge.
- state, output, 2: IDLE=00, START=01, DATA=10, STOP=11.

Behaviour:
- Reset (reset=0, asynchronous): data_o=0, valid=0, busy=0, frame_err=0, overrun=0, state=IDLE, all counters=0, synchronizer flops=1. A reset mid-frame discards the partial word. After release, the block waits for a fresh falling edge.
- Synchronizer: 2-FF on RXD gives rx_s. A third flop gives rx_d for edge detection. All logic uses rx_s only.
- Tick generator: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), truncated, minimum 1. Free-running counter 0..DIV-1. tick=1 for one clk when the count equals DIV-1.
- In the states below, "sample point" means the tick on which the tick count reaches OVERSAMPLE/2-1 (START) or OVERSAMPLE-1 (DATA, STOP).
- IDLE:
  - On rx_d=1 & rx_s=0 (falling edge): clear tick count, go to START.
  - A line held low never re-arms. A high must be seen first.
- START:
  - Count ticks.
  - At tick count OVERSAMPLE/2-1 (mid start bit): if rx_s=0, clear tick count and bit index, go to DATA.
  - If rx_s=1 at that point: false start, return to IDLE with no flags set.
- DATA:
  - At tick count OVERSAMPLE-1 (mid bit): shift rx_s into the shift register at position bit index (LSB first), then increment bit index.
  - After bit index WORD-1 is sampled, go to STOP.
- STOP:
  - At mid stop bit (tick count OVERSAMPLE-1), the following apply:
  - If rx_s=1 and valid=0: data_o ← shift register, valid ← 1.
  - If rx_s=1 and valid=1: overrun ← 1. data_o and valid are unchanged; the new word is dropped.
  - If rx_s=0: frame_err ← 1, the word is discarded, and valid is untouched.
  - In all three cases go to IDLE.
- Latency: valid rises on the clk edge following the stop-bit sample tick.
- Handshake:
  - valid stays high until a clk edge with valid & ready, then falls to 0.
  - data_o is held stable while valid=1.
  - If ready and a new completion hit the same edge, the accept takes priority: the new word loads and valid stays 1, with no overrun.
- err_clr vs a same-cycle error set: the set wins.
- Any illegal state encoding: go to IDLE.
- Reception runs independently of valid. Frames keep being received while valid is high (overrun path).

Test Plan:
- Sim parameters: CLK_FREQ=16_000_000, BAUD_RATE=1_000_000, OVERSAMPLE=16, so DIV=1 and one bit = 16 clk.
- Single frame: drive byte 0xA5 (start, 1,0,1,0,0,1,0,1, stop) with ready=0. Required: valid=1 within 2 clk after the stop-bit midpoint, data_o=0xA5, frame_err=0. Pulse ready=1 for one clk. Required: valid=0.
- Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap while ready=1. Required: three valid handshakes carrying 0x00, 0xFF, 0x55 in order, no flags.
- Framing error: send 0x3C with the stop bit driven 0. Required: frame_err=1, valid stays 0. Pulse err_clr. Required: frame_err=0. Then send 0x3C correctly. Required: data_o=0x3C.
- Glitch and overrun:
  - Pulse RXD low for 4 clk. Required: state returns to IDLE, no valid.
  - With ready=0, send 0x11 then 0x22. Required: data_o stays 0x11, overrun=1.
- Reset mid-frame: assert reset after the 4th data bit of 0x96, release it, then send 0x5A. Required: all outputs 0 and state=IDLE during reset, then valid with data_o=0x5A and no flags.
